// File: rtl/cart_mmc1_gen.sv
// MMC1-family cartridge mapper: serial register loader, PRG/CHR bank expansion,
// banked PRG-RAM and CIRAM mirroring, with optional rejection of back-to-back writes.
module cart_mmc1_gen #(
    parameter int PRG_BANK_BITS = 4,
    parameter int CHR_BANK_BITS = 5,
    parameter int PRG_RAM_BANKS = 1,
    parameter int CHR_IS_RAM    = 1,
    parameter int WRITE_GAP     = 2
) (
    input  logic                                 clk_sys,
    input  logic                                 rst_n,
    input  logic                                 prg_nce_in,
    input  logic [14:0]                          prg_a_in,
    input  logic                                 prg_r_nw_in,
    input  logic [7:0]                           prg_d_in,
    input  logic [13:0]                          chr_a_in,
    input  logic                                 chr_r_nw_in,
    output logic [PRG_BANK_BITS+13:0]            prg_rom_addr,
    output logic [12+$clog2(PRG_RAM_BANKS):0]    prg_ram_addr,
    output logic                                 prg_ram_ce,
    output logic                                 prg_ram_we,
    output logic [CHR_BANK_BITS+11:0]            chr_addr,
    output logic                                 chr_we,
    output logic                                 ciram_nce_out,
    output logic                                 ciram_a10_out,
    output logic                                 reg_wr,
    output logic [4:0]                           debug
);
    localparam int GAP_W = (WRITE_GAP > 0) ? $clog2(WRITE_GAP + 1) : 1;

    logic [4:0]       shift, control, chr_bank_0, chr_bank_1, prg_bank;
    logic [4:0]       shift_next;
    logic             prev_wr, prg_write, wr_accept;
    logic [GAP_W-1:0] gap_cnt;
    logic [3:0]       prg_inner;
    logic [4:0]       chr_bank_raw, chr_bank;

    assign prg_write  = ~prg_nce_in & ~prg_r_nw_in;
    assign wr_accept  = prg_write & ~prev_wr & (gap_cnt == '0);
    assign shift_next = {prg_d_in[0], shift[4:1]};

    // shift[0] reaching 1 marks the fifth bit: the start marker has walked down.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            shift      <= 5'b10000;
            control    <= 5'b01100;
            chr_bank_0 <= 5'b00000;
            chr_bank_1 <= 5'b00000;
            prg_bank   <= 5'b00000;
            prev_wr    <= 1'b0;
            gap_cnt    <= '0;
            reg_wr     <= 1'b0;
        end else begin
            prev_wr <= prg_write;
            reg_wr  <= 1'b0;
            if (wr_accept) begin
                gap_cnt <= GAP_W'(WRITE_GAP);
                if (prg_d_in[7]) begin
                    shift   <= 5'b10000;
                    control <= control | 5'b01100;
                end else if (shift[0]) begin
                    shift  <= 5'b10000;
                    reg_wr <= 1'b1;
                    case (prg_a_in[14:13])
                        2'd0:    control    <= shift_next;
                        2'd1:    chr_bank_0 <= shift_next;
                        2'd2:    chr_bank_1 <= shift_next;
                        default: prg_bank   <= shift_next;
                    endcase
                end else begin
                    shift <= shift_next;
                end
            end else if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        prg_inner = 4'h0;
        if (!control[3])
            prg_inner = {prg_bank[3:1], prg_a_in[14]};
        else if (!control[2])
            prg_inner = prg_a_in[14] ? prg_bank[3:0] : 4'h0;
        else
            prg_inner = prg_a_in[14] ? 4'hF : prg_bank[3:0];
    end

    // With a 512 KB PRG space the CHR bank-0 MSB becomes PRG A18, not a CHR line.
    generate
        if (PRG_BANK_BITS == 5) begin : g_outer
            assign prg_rom_addr = {chr_bank_0[4], prg_inner, prg_a_in[13:0]};
        end else begin : g_no_outer
            assign prg_rom_addr = {prg_inner, prg_a_in[13:0]};
        end

        if (PRG_RAM_BANKS == 4) begin : g_ram4
            assign prg_ram_addr = {chr_bank_0[3:2], prg_a_in[12:0]};
        end else if (PRG_RAM_BANKS == 2) begin : g_ram2
            assign prg_ram_addr = {chr_bank_0[3], prg_a_in[12:0]};
        end else begin : g_ram1
            assign prg_ram_addr = prg_a_in[12:0];
        end
    endgenerate

    assign prg_ram_ce = prg_nce_in & prg_a_in[14] & prg_a_in[13] & ~prg_bank[4];
    assign prg_ram_we = prg_ram_ce & ~prg_r_nw_in;

    always_comb begin
        chr_bank_raw = control[4] ? (chr_a_in[12] ? chr_bank_1 : chr_bank_0)
                                  : {chr_bank_0[4:1], chr_a_in[12]};
        chr_bank = chr_bank_raw;
        if (PRG_BANK_BITS == 5)
            chr_bank[4] = 1'b0;
    end

    assign chr_addr      = {chr_bank[CHR_BANK_BITS-1:0], chr_a_in[11:0]};
    assign chr_we        = (CHR_IS_RAM != 0) & ~chr_a_in[13] & ~chr_r_nw_in;
    assign ciram_nce_out = ~chr_a_in[13];

    always_comb begin
        case (control[1:0])
            2'd0:    ciram_a10_out = 1'b0;
            2'd1:    ciram_a10_out = 1'b1;
            2'd2:    ciram_a10_out = chr_a_in[10];
            default: ciram_a10_out = chr_a_in[11];
        endcase
    end

    assign debug = prg_bank;
endmodule

// File: tb/tb_cart_mmc1_gen.sv
// Bench for cart_mmc1_gen: a default-configured instance and a SUROM-style one
// (512 KB PRG, 4 RAM banks, CHR ROM) share stimulus and are checked against a register-level model.
module tb_cart_mmc1_gen;
    localparam int GAP = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        nce = 1'b1, rnw = 1'b1, crnw = 1'b1;
    logic [14:0] pa = '0;
    logic [7:0]  pd = '0;
    logic [13:0] ca = '0;

    logic [17:0] a_rom;  logic [12:0] a_ram;  logic [16:0] a_chr;
    logic [18:0] b_rom;  logic [14:0] b_ram;  logic [16:0] b_chr;
    logic a_ce, a_we, a_cwe, a_cnce, a_a10, a_reg_wr;
    logic b_ce, b_we, b_cwe, b_cnce, b_a10, b_reg_wr;
    logic [4:0] a_dbg, b_dbg;

    cart_mmc1_gen #(.PRG_BANK_BITS(4), .CHR_BANK_BITS(5), .PRG_RAM_BANKS(1),
                    .CHR_IS_RAM(1), .WRITE_GAP(GAP)) dut_a (
        .clk_sys(clk), .rst_n(rst_n), .prg_nce_in(nce), .prg_a_in(pa),
        .prg_r_nw_in(rnw), .prg_d_in(pd), .chr_a_in(ca), .chr_r_nw_in(crnw),
        .prg_rom_addr(a_rom), .prg_ram_addr(a_ram), .prg_ram_ce(a_ce),
        .prg_ram_we(a_we), .chr_addr(a_chr), .chr_we(a_cwe),
        .ciram_nce_out(a_cnce), .ciram_a10_out(a_a10), .reg_wr(a_reg_wr),
        .debug(a_dbg));

    cart_mmc1_gen #(.PRG_BANK_BITS(5), .CHR_BANK_BITS(5), .PRG_RAM_BANKS(4),
                    .CHR_IS_RAM(0), .WRITE_GAP(GAP)) dut_b (
        .clk_sys(clk), .rst_n(rst_n), .prg_nce_in(nce), .prg_a_in(pa),
        .prg_r_nw_in(rnw), .prg_d_in(pd), .chr_a_in(ca), .chr_r_nw_in(crnw),
        .prg_rom_addr(b_rom), .prg_ram_addr(b_ram), .prg_ram_ce(b_ce),
        .prg_ram_we(b_we), .chr_addr(b_chr), .chr_we(b_cwe),
        .ciram_nce_out(b_cnce), .ciram_a10_out(b_a10), .reg_wr(b_reg_wr),
        .debug(b_dbg));

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: 0=control 1=chr_bank_0 2=chr_bank_1 3=prg_bank; bits collected LSB first.
    int m_reg[4];
    int nbits, acc, last_acc, now, pulses;
    bit mprev, exp_rw;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_reg[0] = 'h0C; m_reg[1] = 0; m_reg[2] = 0; m_reg[3] = 0;
        nbits = 0; acc = 0; last_acc = -1000; mprev = 0; exp_rw = 0;
    endtask

    task automatic model_sample();
        bit w;
        w = !nce && !rnw;
        exp_rw = 0;
        if (!rst_n) begin
            mprev = 0;
        end else begin
            if (w && !mprev && (now - last_acc > GAP)) begin
                last_acc = now;
                if (pd[7]) begin
                    nbits = 0; acc = 0;
                    m_reg[0] = m_reg[0] | 'h0C;
                end else begin
                    acc = acc + (int'(pd[0]) << nbits);
                    nbits++;
                    if (nbits == 5) begin
                        m_reg[int'(pa) / 8192] = acc;
                        nbits = 0; acc = 0; exp_rw = 1;
                    end
                end
            end
            mprev = w;
        end
        now++;
    endtask

    function automatic int e_rom(input int pbb);
        int a, mode, b, outer, r;
        a = int'(pa);
        mode = (m_reg[0] / 4) % 4;
        b = m_reg[3] % 16;
        outer = (pbb == 5) ? (m_reg[1] / 16) % 2 : 0;
        if (mode < 2)       r = (b / 2) * 32768 + a % 32768;
        else if (mode == 2) r = (a >= 16384) ? b * 16384 + a % 16384 : a % 16384;
        else                r = (a >= 16384) ? 15 * 16384 + a % 16384 : b * 16384 + a % 16384;
        return r + outer * 262144;
    endfunction

    function automatic int e_ram_addr(input int banks);
        int bank;
        bank = (banks == 4) ? (m_reg[1] / 4) % 4 : (banks == 2) ? (m_reg[1] / 8) % 2 : 0;
        return bank * 8192 + int'(pa) % 8192;
    endfunction

    function automatic int e_chr(input int pbb, input int cbb);
        int c, r, bank;
        c = int'(ca) % 8192;
        if ((m_reg[0] / 16) % 2 == 1) begin
            bank = (c >= 4096) ? m_reg[2] : m_reg[1];
            r = bank * 4096 + c % 4096;
        end else begin
            r = (m_reg[1] / 2) * 8192 + c;
        end
        if (pbb == 5) r = r % 65536;
        return r % (1 << (cbb + 12));
    endfunction

    function automatic int e_a10();
        case (m_reg[0] % 4)
            0: return 0;
            1: return 1;
            2: return (int'(ca) / 1024) % 2;
            default: return (int'(ca) / 2048) % 2;
        endcase
    endfunction

    task automatic check_all();
        int ce;
        ce = (nce && int'(pa) >= 'h6000 && m_reg[3] < 16) ? 1 : 0;
        chk("a_rom", a_rom, e_rom(4));
        chk("b_rom", b_rom, e_rom(5));
        chk("a_ram_addr", a_ram, e_ram_addr(1));
        chk("b_ram_addr", b_ram, e_ram_addr(4));
        chk("a_ram_ce", a_ce, ce);
        chk("b_ram_ce", b_ce, ce);
        chk("a_ram_we", a_we, ce & int'(!rnw));
        chk("b_ram_we", b_we, ce & int'(!rnw));
        chk("a_chr", a_chr, e_chr(4, 5));
        chk("b_chr", b_chr, e_chr(5, 5));
        chk("a_chr_we", a_cwe, (ca < 14'h2000 && !crnw) ? 1 : 0);
        chk("b_chr_we", b_cwe, 0);
        chk("a_ciram_nce", a_cnce, (ca < 14'h2000) ? 1 : 0);
        chk("b_ciram_nce", b_cnce, (ca < 14'h2000) ? 1 : 0);
        chk("a_a10", a_a10, e_a10());
        chk("b_a10", b_a10, e_a10());
        chk("a_debug", a_dbg, m_reg[3]);
        chk("b_debug", b_dbg, m_reg[3]);
    endtask

    task automatic tick();
        model_sample();
        @(posedge clk);
        #1;
        chk("a_reg_wr", a_reg_wr, exp_rw);
        chk("b_reg_wr", b_reg_wr, exp_rw);
        if (a_reg_wr) pulses++;
    endtask

    task automatic wr(input int a, input int d, input int idle);
        nce = 0; rnw = 0; pa = 15'(a); pd = 8'(d);
        tick();
        nce = 1; rnw = 1;
        repeat (idle) tick();
    endtask

    task automatic wr5(input int a, input int v);
        for (int i = 0; i < 5; i++) wr(a, (v >> i) & 1, 3);
    endtask

    task automatic drive(input int a, input bit n, input bit r, input int c, input bit cr);
        pa = 15'(a); nce = n; rnw = r; ca = 14'(c); crnw = cr;
        #1;
    endtask

    initial begin
        now = 0; pulses = 0;
        model_reset();
        #1 rst_n = 0;
        drive('h4000, 0, 1, 'h0000, 1);
        chk("rst_a_rom", a_rom, 'h3C000);
        chk("rst_a_ram_ce", a_ce, 0);
        chk("rst_b_ram_ce", b_ce, 0);
        chk("rst_a10", a_a10, 0);
        chk("rst_reg_wr", a_reg_wr, 0);
        chk("rst_debug", a_dbg, 0);
        check_all();
        tick(); tick();
        rst_n = 1;
        drive(0, 1, 1, 0, 1);
        tick();

        // prg_bank load, one completion pulse
        pulses = 0;
        wr5('h6000, 5);
        chk("load_pulses", pulses, 1);
        chk("load_prg_bank", a_dbg, 5'b00101);
        drive('h0123, 0, 1, 'h0800, 1);
        chk("load_rom", a_rom, 'h14123);
        check_all();

        // second write inside the gap is dropped
        wr('h6000, 1, 1);
        wr('h6000, 0, 3);
        wr('h6000, 1, 3); wr('h6000, 1, 3); wr('h6000, 0, 3); wr('h6000, 0, 3);
        chk("gap_prg_bank", a_dbg, 7);
        check_all();

        // reset write in the middle of a sequence
        wr5('h0000, 3);
        wr('h6000, 1, 3); wr('h6000, 1, 3); wr('h6000, 1, 3);
        wr('h6000, 'h80, 3);
        drive('h4000, 0, 1, 'h0800, 1);
        chk("rstwr_rom", a_rom, 'h3C000);
        chk("rstwr_a10", a_a10, 1);
        wr5('h6000, 2);
        chk("rstwr_prg_bank", a_dbg, 2);
        check_all();

        // outer PRG bank on the 512 KB instance
        wr5('h2000, 16);
        drive('h4000, 0, 1, 'h1234, 1);
        chk("surom_b_rom", b_rom, 'h7C000);
        chk("surom_a_chr", a_chr, 'h11234);
        chk("surom_b_chr", b_chr, 'h01234);
        check_all();

        // banked PRG-RAM, then disabled by prg_bank[4]
        wr5('h2000, 12);
        drive('h6010, 1, 0, 'h2000, 1);
        chk("ram_b_addr", b_ram, 'h6010);
        chk("ram_b_we", b_we, 1);
        chk("ram_a_addr", a_ram, 'h0010);
        check_all();
        wr5('h6000, 16);
        drive('h6010, 1, 0, 'h2000, 1);
        chk("ram_dis_ce", b_ce, 0);
        check_all();

        // asynchronous reset discards partial shift contents
        wr('h6000, 1, 3); wr('h6000, 1, 2);
        #2 rst_n = 0;
        model_reset();
        #1 chk("arst_debug", a_dbg, 0);
        tick();
        rst_n = 1;
        tick();
        wr5('h6000, 1);
        chk("arst_prg_bank", a_dbg, 1);

        // held write counts once
        nce = 0; rnw = 0; pa = 15'h6000; pd = 8'h01;
        repeat (6) tick();
        nce = 1; rnw = 1;
        repeat (3) tick();
        check_all();

        // randomized traffic
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 9) < 7) begin
                pd = 8'($urandom_range(0, 127) | (($urandom_range(0, 7) == 0) ? 128 : 0));
                pa = 15'($urandom_range(0, 32767));
                nce = 0; rnw = 0;
                ca = 14'($urandom_range(0, 16383)); crnw = 1'($urandom_range(0, 1));
                repeat ($urandom_range(1, 3)) begin
                    tick();
                    check_all();
                end
            end
            repeat ($urandom_range(0, 4)) begin
                rnw = 1'($urandom_range(0, 1));
                nce = rnw ? 1'($urandom_range(0, 1)) : 1'b1;
                pa = 15'($urandom_range(0, 32767));
                ca = 14'($urandom_range(0, 16383)); crnw = 1'($urandom_range(0, 1));
                tick();
                check_all();
            end
            nce = 1; rnw = 1;
            tick();
            check_all();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cart_mmc1_gen.md
# cart_mmc1_gen

Parametrised MMC1-family mapper core for the cartridge slot. It serially loads the four MMC1 registers from CPU writes. It drives bank-expanded addresses and strobes to external PRG-ROM, PRG-RAM and CHR memories, and it drives the CIRAM controls. Compared with the fixed SNROM-style mapper it adds the following:
- a configurable PRG outer bank (SUROM/SXROM, up to 512 KB);
- banked PRG-RAM (up to 32 KB);
- CHR ROM or RAM selection;
- rejection of back-to-back writes.

## Interface
Parameters:
- PRG_BANK_BITS, 4: 16 KB PRG bank index width, 4 or 5. When set to 5, chr_bank_0[4] is the outer bank bit (PRG A18).
- CHR_BANK_BITS, 5: 4 KB CHR bank index width, 1..5.
- PRG_RAM_BANKS, 1: number of 8 KB PRG-RAM banks, 1, 2 or 4. The bank is selected by chr_bank_0[3] (2 banks) or chr_bank_0[3:2] (4 banks).
- CHR_IS_RAM, 1: when 1, chr_we is enabled; when 0, chr_we is tied to 0.
- WRITE_GAP, 2: number of clocks after an accepted write during which further serial writes are ignored. 0 disables the gap.

Ports:
- clk_sys  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- prg_nce_in  in  1  PRG-ROM chip enable, active low ($8000-$FFFF).
- prg_a_in  in  15  CPU address bits [14:0].
- prg_r_nw_in  in  1  CPU read/write select (1 = read).
- prg_d_in  in  8  CPU write data.
- chr_a_in  in  14  PPU address.
- chr_r_nw_in  in  1  PPU read/write select.
- prg_rom_addr  out  PRG_BANK_BITS+14  PRG-ROM byte address.
- prg_ram_addr  out  13+log2(PRG_RAM_BANKS)  PRG-RAM byte address.
- prg_ram_ce  out  1  PRG-RAM access enable.
- prg_ram_we  out  1  PRG-RAM write strobe.
- chr_addr  out  CHR_BANK_BITS+12  CHR byte address.
- chr_we  out  1  CHR-RAM write strobe.
- ciram_nce_out  out  1  CIRAM chip enable, active low.
- ciram_a10_out  out  1  CIRAM A10 (mirroring).
- reg_wr  out  1  one-cycle pulse on each completed 5-bit register load.
- debug  out  5  current prg_bank register.

## Operation
- Write detection:
  - prg_write = ~prg_nce_in & ~prg_r_nw_in.
  - A registered copy prev_wr is kept each cycle.
  - An edge occurs when prg_write & ~prev_wr.
- Gap counter gap_cnt:
  - It is loaded with WRITE_GAP on every accepted edge and decrements to 0 otherwise.
  - An edge is accepted only when gap_cnt == 0.
  - Edges arriving while gap_cnt != 0 are dropped entirely: the shift register is untouched and gap_cnt is not reloaded.
- Accepted edge with d[7] = 1 (reset write):
  - shift <= 5'b10000;
  - control <= control | 5'b01100;
  - no reg_wr pulse.
- Accepted edge with d[7] = 0 and shift[0] = 0: shift <= {d[0], shift[4:1]}.
- Accepted edge with d[7] = 0 and shift[0] = 1:
  - The value {d[0], shift[4:1]} is written to the register selected by prg_a_in[14:13]: 0 = control, 1 = chr_bank_0, 2 = chr_bank_1, 3 = prg_bank.
  - shift <= 5'b10000.
  - reg_wr = 1 for the next cycle.
- PRG bank selection, with b = prg_bank[3:0] and o = outer bit (chr_bank_0[4] when PRG_BANK_BITS = 5):
  - control[3] = 0: bank {o, b[3:1], a14}.
  - control[3:2] = 2'b10: bank {o, a14 ? b : 4'h0}.
  - control[3:2] = 2'b11: bank {o, a14 ? 4'hF : b}.
  - prg_rom_addr = {bank, a[13:0]}.
- PRG-RAM:
  - prg_ram_ce = prg_nce_in & a14 & a13 & ~prg_bank[4].
  - prg_ram_we = prg_ram_ce & ~prg_r_nw_in.
  - The address is {ram_bank, a[12:0]}.
- CHR bank selection:
  - control[4] = 0: bank {chr_bank_0[4:1], chr_a_in[12]}.
  - control[4] = 1: chr_a_in[12] ? chr_bank_1 : chr_bank_0.
  - The bank is truncated to CHR_BANK_BITS.
  - When PRG_BANK_BITS = 5, bank bit 4 is forced to 0.
- ciram_nce_out = ~chr_a_in[13].
- chr_we = CHR_IS_RAM & ~chr_a_in[13] & ~chr_r_nw_in.
- ciram_a10_out by control[1:0]:
  - 0 → 0;
  - 1 → 1;
  - 2 → chr_a_in[10];
  - 3 → chr_a_in[11].

## Timing
- Reset (rst_n low, asynchronous), all registers:
  - shift = 10000, control = 01100;
  - chr_bank_0 = 0, chr_bank_1 = 0, prg_bank = 0;
  - prev_wr = 0, gap_cnt = 0, reg_wr = 0.
- Outputs during reset:
  - ciram_a10_out = 0.
  - The $C000 window maps the last bank, i.e. prg_rom_addr[17:14] = 4'hF.
- Register update latency: registers update at the first clk_sys edge that samples prg_write high. The combinational outputs reflect the new value in the following cycle.
- A write held across many cycles counts as one edge.
- Reset mid-sequence discards any partial shift contents.
- A reset write during the gap is dropped, like any other edge.
- All address and strobe outputs are combinational from inputs and registers, with zero latency.

## Test plan
- Reset checks:
  - rst_n low → prg_ram_ce = 0 with prg_nce_in = 0.
  - rst_n low, a = $4000 → prg_rom_addr = 0x3C000 | a[13:0] (PRG_BANK_BITS = 4).
- Prg_bank load: five writes to $E000 with d[0] = 1,0,1,0,0, spaced more than WRITE_GAP apart:
  - prg_bank = 5'b00101;
  - reg_wr pulses once;
  - a = $0123 reads prg_rom_addr = 0x14123.
- Gap rejection: writes at consecutive edges within WRITE_GAP = 2 → only the first shifts; shift = {d0, 1000} after two writes.
- Reset write: after 3 bits have been shifted, write 0x80 → shift = 10000 and control[3:2] = 11. The next five writes load cleanly.
- SUROM with PRG_BANK_BITS = 5:
  - chr_bank_0 = 5'b10000 and mode 3, a = $4000 → prg_rom_addr = 0x7C000.
  - CHR bank bit 4 = 0.
- PRG-RAM with PRG_RAM_BANKS = 4, chr_bank_0 = 5'b01100:
  - a = $6010 write → prg_ram_addr = 0x6010 and prg_ram_we = 1.
  - After prg_bank[4] = 1 → prg_ram_ce = 0.
